// File: rtl/key_gen_pkg.sv
// Shared types and helpers for the key generator datapath.
package key_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to hold a Hamming weight in the range 0..key_w.
  function automatic int unsigned weight_width(input int unsigned key_w);
    return $clog2(key_w + 1);
  endfunction

  // Increment that sticks at the all-ones value of a w-bit counter (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v == max_v) ? v : (v + 64'd1);
  endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word fall-through FIFO; head reads as zero while empty.
module key_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_push,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_pop,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_full,
  output logic             out_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Status flags and gated push/pop strobes.
  always_comb begin
    out_empty = (count == '0);
    out_full  = (count == (AW + 1)'(DEPTH));
    out_valid = !out_empty;
    do_push   = in_push && !out_full;
    do_pop    = in_pop && !out_empty;
    out_data  = out_empty ? '0 : mem[rd_ptr];
  end

  // Storage write; contents need no reset because the head is masked when empty.
  always_ff @(posedge in_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_weight_filter.sv
// Hamming-weight window filter for key candidates with an output FIFO and
// a programmable stop count. Optional reject counter: KEY_WEIGHT_FILTER_STATS_EN.
module key_weight_filter
  import key_gen_pkg::*;
#(
  parameter int unsigned KEY_W = 128,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned WW = weight_width(KEY_W)
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_wr_cfg,
  input  logic [WW-1:0]    in_cfg_weight_lo,
  input  logic [WW-1:0]    in_cfg_weight_hi,
  input  logic [CNT_W-1:0] in_cfg_key_limit,
  input  logic             in_start,
  input  logic             in_cand_valid,
  output logic             out_cand_ready,
  input  logic [WW-1:0]    in_hamming_weight,
  input  logic [KEY_W-1:0] in_key_candidate,
  output logic             out_key_valid,
  input  logic             in_key_ready,
  output logic [KEY_W-1:0] out_key,
  output logic             out_busy,
  output logic             out_done,
  output logic [CNT_W-1:0] out_found_count
`ifdef KEY_WEIGHT_FILTER_STATS_EN
  ,
  output logic [CNT_W-1:0] out_reject_count
`endif
);

  state_t           state_q;
  state_t           state_d;
  logic [WW-1:0]    lo_q;
  logic [WW-1:0]    hi_q;
  logic [CNT_W-1:0] limit_q;
  logic [CNT_W-1:0] found_q;
  logic [CNT_W-1:0] found_inc;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             match;
  logic             push;
  logic             start_ok;
  logic             cfg_ok;

  // Handshake, window compare and control strobes.
  always_comb begin
    out_cand_ready = (state_q == ST_RUN) && !fifo_full;
    accept         = in_cand_valid && out_cand_ready;
    match          = (in_hamming_weight >= lo_q) && (in_hamming_weight <= hi_q);
    push           = accept && match;
    cfg_ok         = in_wr_cfg && (state_q != ST_RUN);
    start_ok       = in_start && (state_q != ST_RUN) && fifo_empty;
    found_inc      = CNT_W'(sat_inc(64'(found_q), CNT_W));
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    state_d  = state_q;
    out_busy = 1'b0;
    out_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_RUN;
      end
      ST_RUN: begin
        out_busy = 1'b1;
        if (push && (limit_q != '0) && (found_inc == limit_q)) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_done = 1'b1;
        if (start_ok) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge in_clk) begin
    if (in_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Configuration registers, writable only outside a run.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      lo_q    <= '0;
      hi_q    <= '0;
      limit_q <= '0;
    end else if (cfg_ok) begin
      lo_q    <= in_cfg_weight_lo;
      hi_q    <= in_cfg_weight_hi;
      limit_q <= in_cfg_key_limit;
    end
  end

  // Found counter: cleared on an accepted start, bumped per pushed match.
  always_ff @(posedge in_clk) begin
    if (in_rst)        found_q <= '0;
    else if (start_ok) found_q <= '0;
    else if (push)     found_q <= found_inc;
  end

  always_comb out_found_count = found_q;

`ifdef KEY_WEIGHT_FILTER_STATS_EN
  logic [CNT_W-1:0] reject_q;

  // Reject counter: accepted candidates that fall outside the window.
  always_ff @(posedge in_clk) begin
    if (in_rst)                 reject_q <= '0;
    else if (start_ok)          reject_q <= '0;
    else if (accept && !match)  reject_q <= CNT_W'(sat_inc(64'(reject_q), CNT_W));
  end

  always_comb out_reject_count = reject_q;
`else
  // Without statistics, non-matching candidates are dropped silently.
`endif

  key_fifo #(
    .WIDTH(KEY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_push  (push),
    .in_data  (in_key_candidate),
    .in_pop   (in_key_ready),
    .out_data (out_key),
    .out_valid(out_key_valid),
    .out_full (fifo_full),
    .out_empty(fifo_empty)
  );

endmodule

// File: tb/tb_key_weight_filter.sv
// Directed self-checking bench for key_weight_filter (KEY_W=128, DEPTH=4, CNT_W=16).
module tb_key_weight_filter;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_cfg;
  logic [7:0]   cfg_lo;
  logic [7:0]   cfg_hi;
  logic [15:0]  cfg_limit;
  logic         start;
  logic         cand_valid;
  logic         cand_ready;
  logic [7:0]   weight;
  logic [127:0] cand;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic [15:0]  found;
`ifdef KEY_WEIGHT_FILTER_STATS_EN
  logic [15:0]  reject;
`endif

  int unsigned checks = 0;
  int unsigned failures = 0;

  key_weight_filter #(
    .KEY_W(128),
    .DEPTH(4),
    .CNT_W(16)
  ) dut (
    .in_clk           (clk),
    .in_rst           (rst),
    .in_wr_cfg        (wr_cfg),
    .in_cfg_weight_lo (cfg_lo),
    .in_cfg_weight_hi (cfg_hi),
    .in_cfg_key_limit (cfg_limit),
    .in_start         (start),
    .in_cand_valid    (cand_valid),
    .out_cand_ready   (cand_ready),
    .in_hamming_weight(weight),
    .in_key_candidate (cand),
    .out_key_valid    (key_valid),
    .in_key_ready     (key_ready),
    .out_key          (key),
    .out_busy         (busy),
    .out_done         (done),
    .out_found_count  (found)
`ifdef KEY_WEIGHT_FILTER_STATS_EN
    ,
    .out_reject_count (reject)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         valid;
    logic [7:0]   w;
    logic [127:0] k;
    logic         exp_kv;
    logic [127:0] exp_key;
    logic [15:0]  exp_found;
  } vec_t;

  vec_t tbl [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_cfg_start(input logic [7:0] lo, input logic [7:0] hi, input logic [15:0] lim);
    wr_cfg = 1'b1; start = 1'b1;
    cfg_lo = lo; cfg_hi = hi; cfg_limit = lim;
    tick();
    wr_cfg = 1'b0; start = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] lim_w [7];

    rst = 1'b1; wr_cfg = 1'b0; cfg_lo = '0; cfg_hi = '0; cfg_limit = '0;
    start = 1'b0; cand_valid = 1'b0; weight = '0; cand = '0; key_ready = 1'b0;

    tbl[0] = '{1'b1, 8'd63, 128'hA0, 1'b0, 128'h0,  16'd0};
    tbl[1] = '{1'b1, 8'd64, 128'hA1, 1'b1, 128'hA1, 16'd1};
    tbl[2] = '{1'b1, 8'd65, 128'hA2, 1'b0, 128'h0,  16'd1};
    tbl[3] = '{1'b1, 8'd64, 128'hA3, 1'b1, 128'hA3, 16'd2};
    tbl[4] = '{1'b0, 8'd64, 128'hA4, 1'b0, 128'h0,  16'd2};

    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_key",        key,               128'h0);
    chk("rst_key_valid",  128'(key_valid),   128'h0);
    chk("rst_cand_ready", 128'(cand_ready),  128'h0);
    chk("rst_busy",       128'(busy),        128'h0);
    chk("rst_done",       128'(done),        128'h0);
    chk("rst_found",      128'(found),       128'h0);

    // Exact-weight run lo = hi = 64, unlimited
    key_ready = 1'b1;
    write_cfg_start(8'd64, 8'd64, 16'd0);
    chk("exact_busy",       128'(busy),       128'h1);
    chk("exact_cand_ready", 128'(cand_ready), 128'h1);
    for (int i = 0; i < 5; i++) begin
      cand_valid = tbl[i].valid; weight = tbl[i].w; cand = tbl[i].k;
      tick();
      chk("exact_kv",    128'(key_valid), 128'(tbl[i].exp_kv));
      chk("exact_key",   key,             tbl[i].exp_key);
      chk("exact_found", 128'(found),     128'(tbl[i].exp_found));
    end
    cand_valid = 1'b0;
`ifdef KEY_WEIGHT_FILTER_STATS_EN
    chk("exact_reject", 128'(reject), 128'd2);
`endif

    // Config write during RUN must not change the window
    wr_cfg = 1'b1; cfg_lo = 8'd0; cfg_hi = 8'd200;
    tick();
    wr_cfg = 1'b0;
    cand_valid = 1'b1; weight = 8'd10; cand = 128'hB0;
    tick();
    chk("runcfg_found_a", 128'(found),     128'd2);
    chk("runcfg_kv_a",    128'(key_valid), 128'h0);
    weight = 8'd64; cand = 128'hB1;
    tick();
    chk("runcfg_found_b", 128'(found), 128'd3);
    chk("runcfg_key_b",   key,         128'hB1);
    cand_valid = 1'b0;
`ifdef KEY_WEIGHT_FILTER_STATS_EN
    chk("runcfg_reject", 128'(reject), 128'd3);
`endif
    tick();

    // Limit run lo = 10, hi = 20, limit = 3, with boundary rejects 9 and 21
    pulse_reset();
    write_cfg_start(8'd10, 8'd20, 16'd3);
    lim_w = '{8'd9, 8'd21, 8'd10, 8'd20, 8'd15, 8'd12, 8'd18};
    for (int i = 0; i < 7; i++) begin
      cand_valid = 1'b1; weight = lim_w[i]; cand = 128'h100 + 128'(i);
      tick();
      if (i < 2) begin
        chk("lim_found_pre", 128'(found),     128'd0);
        chk("lim_kv_pre",    128'(key_valid), 128'h0);
      end else if (i < 5) begin
        chk("lim_found",     128'(found), 128'(i - 1));
        chk("lim_key",       key,         128'h100 + 128'(i));
        chk("lim_done",      128'(done),  128'(i == 4));
        chk("lim_busy",      128'(busy),  128'(i != 4));
      end else begin
        chk("lim_found_post", 128'(found),      128'd3);
        chk("lim_kv_post",    128'(key_valid),  128'h0);
        chk("lim_ready_post", 128'(cand_ready), 128'h0);
        chk("lim_done_post",  128'(done),       128'h1);
      end
    end
    cand_valid = 1'b0;
`ifdef KEY_WEIGHT_FILTER_STATS_EN
    chk("lim_reject", 128'(reject), 128'd2);
`endif

    // Start with a non-empty FIFO is ignored
    key_ready = 1'b0;
    write_cfg_start(8'd5, 8'd5, 16'd1);
    cand_valid = 1'b1; weight = 8'd5; cand = 128'hC0;
    tick();
    cand_valid = 1'b0;
    chk("nes_done_a",  128'(done),  128'h1);
    chk("nes_found_a", 128'(found), 128'd1);
    chk("nes_key_a",   key,         128'hC0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("nes_busy",  128'(busy),  128'h0);
    chk("nes_done",  128'(done),  128'h1);
    chk("nes_found", 128'(found), 128'd1);
    chk("nes_key",   key,         128'hC0);
    key_ready = 1'b1;
    tick();
    chk("nes_drained", 128'(key_valid), 128'h0);

    // lo > hi matches nothing
    write_cfg_start(8'd30, 8'd5, 16'd0);
    chk("inv_busy", 128'(busy), 128'h1);
    for (int i = 0; i < 100; i++) begin
      cand_valid = 1'b1; weight = 8'(i); cand = 128'(i + 1);
      tick();
      chk("inv_kv", 128'(key_valid), 128'h0);
    end
    cand_valid = 1'b0;
    chk("inv_found", 128'(found), 128'd0);
`ifdef KEY_WEIGHT_FILTER_STATS_EN
    chk("inv_reject", 128'(reject), 128'd100);
`endif

    // Backpressure: DEPTH = 4, consumer stalled
    pulse_reset();
    key_ready = 1'b0;
    write_cfg_start(8'd0, 8'd128, 16'd0);
    for (int i = 0; i < 5; i++) begin
      cand_valid = 1'b1; weight = 8'd64; cand = 128'h200 + 128'(i);
      tick();
      chk("bp_ready", 128'(cand_ready), 128'(i < 3));
      chk("bp_head",  key,              128'h200);
      chk("bp_found", 128'(found),      128'((i < 4) ? i + 1 : 4));
    end
    cand_valid = 1'b0;
    key_ready = 1'b1;
    for (int j = 1; j < 5; j++) begin
      tick();
      chk("bp_ready_drain", 128'(cand_ready), 128'h1);
      chk("bp_kv_drain",    128'(key_valid),  128'(j < 4));
      chk("bp_key_drain",   key,              (j < 4) ? 128'h200 + 128'(j) : 128'h0);
    end

    // Reset mid-run with two keys buffered
    pulse_reset();
    key_ready = 1'b0;
    write_cfg_start(8'd0, 8'd200, 16'd0);
    for (int i = 0; i < 2; i++) begin
      cand_valid = 1'b1; weight = 8'd50; cand = 128'h300 + 128'(i);
      tick();
    end
    cand_valid = 1'b0;
    chk("mr_found_pre", 128'(found),     128'd2);
    chk("mr_kv_pre",    128'(key_valid), 128'h1);
    rst = 1'b1;
    tick();
    chk("mr_busy",  128'(busy),       128'h0);
    chk("mr_done",  128'(done),       128'h0);
    chk("mr_kv",    128'(key_valid),  128'h0);
    chk("mr_key",   key,              128'h0);
    chk("mr_found", 128'(found),      128'd0);
    chk("mr_ready", 128'(cand_ready), 128'h0);
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
